// File: rtl/pcie_tlp_pkg.sv
// Shared TLP header field definitions, type/link codes and the header DW slicing helper.
package pcie_tlp_pkg;

  localparam int FMT_MSB  = 31;
  localparam int FMT_LSB  = 29;
  localparam int TYPE_MSB = 28;
  localparam int TYPE_LSB = 24;

  typedef logic [2:0] tlp_fmt_t;
  typedef logic [4:0] tlp_type_t;
  typedef logic [2:0] link_t;

  localparam tlp_type_t TYPE_MEM   = 5'b00000;
  localparam tlp_type_t TYPE_MEMLK = 5'b00001;
  localparam tlp_type_t TYPE_IO    = 5'b00010;
  localparam tlp_type_t TYPE_CFG0  = 5'b00100;
  localparam tlp_type_t TYPE_CFG1  = 5'b00101;

  localparam link_t LINK_CFG  = 3'd1;
  localparam link_t LINK_IO   = 3'd2;
  localparam link_t LINK_MEM3 = 3'd3;
  localparam link_t LINK_MEM4 = 3'd4;

  typedef enum logic {ST_IDLE, ST_HOLD} sorter_state_t;

  function automatic logic [31:0] get_dw(input logic [127:0] hdr, input logic [1:0] idx);
    return hdr[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/tlp_route_decode.sv
// Combinational Fmt/Type decode: header length and destination link.
module tlp_route_decode
  import pcie_tlp_pkg::*;
#(
  parameter int LINK_NUMBER = 0
) (
  input  logic [2:0] fmt,
  input  logic [4:0] tlp_type,
  output logic       is_4dw,
  output logic [2:0] link_destination
);

  localparam link_t DEFAULT_LINK = link_t'(LINK_NUMBER);

  assign is_4dw = fmt[0];

  always_comb begin
    link_destination = DEFAULT_LINK;
    if (tlp_type == TYPE_CFG0 || tlp_type == TYPE_CFG1)
      link_destination = LINK_CFG;
    else if (tlp_type == TYPE_IO)
      link_destination = LINK_IO;
    else if (tlp_type == TYPE_MEM || tlp_type == TYPE_MEMLK)
      link_destination = is_4dw ? LINK_MEM4 : LINK_MEM3;
  end

endmodule

// File: rtl/pcie_header_sorter.sv
// Captures one TLP header plus first payload DW, reorders it for the ILR and holds it until next_ready.
//   state   | meaning
//   ST_IDLE | waiting for a non-zero header; captures it on the next edge
//   ST_HOLD | outputs frozen, new headers dropped, leaves on next_ready
module pcie_header_sorter
  import pcie_tlp_pkg::*;
#(
  parameter int LINK_NUMBER = 0,
  parameter int DATA_WIDTH  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_data_header,
  input  logic [31:0]  in_data_payload,
  input  logic         next_ready,
  output logic [95:0]  sorted_header,
  output logic [31:0]  pass_through_payload,
  output logic [2:0]   link_destination
);

  if (DATA_WIDTH < 32) begin : g_bad_width
    $error("pcie_header_sorter: DATA_WIDTH must be >= 32");
  end

  sorter_state_t state;
  logic [31:0]   dw0, dw1, dw2, dw3;
  logic          hdr_present;
  logic          is_4dw;
  logic [2:0]    link_next;

  assign dw0 = get_dw(in_data_header, 2'd0);
  assign dw1 = get_dw(in_data_header, 2'd1);
  assign dw2 = get_dw(in_data_header, 2'd2);
  assign dw3 = get_dw(in_data_header, 2'd3);

  // DW3 is excluded so a stray upper word on an idle bus is not taken as a header
  assign hdr_present = |in_data_header[95:0];

  tlp_route_decode #(
    .LINK_NUMBER(LINK_NUMBER)
  ) u_route_decode (
    .fmt              (dw0[FMT_MSB:FMT_LSB]),
    .tlp_type         (dw0[TYPE_MSB:TYPE_LSB]),
    .is_4dw           (is_4dw),
    .link_destination (link_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      sorted_header        <= '0;
      pass_through_payload <= '0;
      link_destination     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_present) begin
            sorted_header        <= is_4dw ? {dw1, dw3, dw0} : {dw1, dw2, dw0};
            pass_through_payload <= in_data_payload;
            link_destination     <= link_next;
            state                <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (next_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_header_sorter.sv
// Directed table-driven bench for pcie_header_sorter, one table row per clock edge.
module tb_pcie_header_sorter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data_header;
  logic [31:0]  in_data_payload;
  logic         next_ready;
  logic [95:0]  sorted_header;
  logic [31:0]  pass_through_payload;
  logic [2:0]   link_destination;

  int total = 0;
  int bad   = 0;

  pcie_header_sorter #(
    .LINK_NUMBER(5),
    .DATA_WIDTH (64)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_data_header       (in_data_header),
    .in_data_payload      (in_data_payload),
    .next_ready           (next_ready),
    .sorted_header        (sorted_header),
    .pass_through_payload (pass_through_payload),
    .link_destination     (link_destination)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [127:0] hdr;
    logic [31:0]  pay;
    logic         nr;
    logic [95:0]  e_sorted;
    logic [31:0]  e_pay;
    logic [2:0]   e_link;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] H_CFG   = 128'h00000000_FFFFFFFF_AAAAAA0F_048FC001;
  localparam logic [127:0] H_IO    = 128'h00000000_FFFFFFFF_AAAAAA07_028FC001;
  localparam logic [127:0] H_MEM4  = 128'h80000000_00000001_0100000F_60000001;
  localparam logic [127:0] H_MEM3  = 128'h33333333_22222222_11111111_00000001;
  localparam logic [127:0] H_CPL   = 128'h00000000_00000000_01000000_4A000001;
  localparam logic [127:0] H_LK4   = 128'hCCCC0003_BBBB0002_AAAA0001_21000004;
  localparam logic [127:0] H_CFG1  = 128'h00000000_00000002_00000001_45000001;
  localparam logic [127:0] H_DW3   = 128'hDEADBEEF_00000000_00000000_00000000;
  localparam logic [127:0] H_DW1   = 128'h00000000_00000000_00000005_00000000;

  localparam logic [95:0] S_CFG  = 96'hAAAAAA0F_FFFFFFFF_048FC001;
  localparam logic [95:0] S_IO   = 96'hAAAAAA07_FFFFFFFF_028FC001;
  localparam logic [95:0] S_MEM4 = 96'h0100000F_80000000_60000001;
  localparam logic [95:0] S_MEM3 = 96'h11111111_22222222_00000001;
  localparam logic [95:0] S_CPL  = 96'h01000000_00000000_4A000001;
  localparam logic [95:0] S_LK4  = 96'hAAAA0001_CCCC0003_21000004;
  localparam logic [95:0] S_CFG1 = 96'h00000001_00000002_45000001;
  localparam logic [95:0] S_DW1  = 96'h00000005_00000000_00000000;

  task automatic add(input logic r, input logic [127:0] h, input logic [31:0] p, input logic n,
                     input logic [95:0] es, input logic [31:0] ep, input logic [2:0] el);
    vec_t v;
    v.rst = r; v.hdr = h; v.pay = p; v.nr = n;
    v.e_sorted = es; v.e_pay = ep; v.e_link = el;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [95:0] es, input logic [31:0] ep,
                               input logic [2:0] el);
    total++;
    if (sorted_header !== es) begin
      bad++;
      $display("FAIL %s sorted_header: got %h want %h", tag, sorted_header, es);
    end
    total++;
    if (pass_through_payload !== ep) begin
      bad++;
      $display("FAIL %s payload: got %h want %h", tag, pass_through_payload, ep);
    end
    total++;
    if (link_destination !== el) begin
      bad++;
      $display("FAIL %s link: got %0d want %0d", tag, link_destination, el);
    end
  endtask

  task automatic step(input logic r, input logic [127:0] h, input logic [31:0] p, input logic n);
    @(negedge clk);
    rst = r; in_data_header = h; in_data_payload = p; next_ready = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data_header = '0; in_data_payload = '0; next_ready = 1'b0;

    //   rst  header  payload        nr    exp sorted  exp payload    link
    add(1'b1, '0,     32'h0,         1'b0, '0,         32'h0,         3'd0); // reset
    add(1'b0, H_CFG,  32'hCAFEBABE,  1'b0, S_CFG,      32'hCAFEBABE,  3'd1); // capture cfg0
    add(1'b0, H_CFG,  32'hCAFEBABE,  1'b0, S_CFG,      32'hCAFEBABE,  3'd1); // stable
    add(1'b0, H_IO,   32'h12345678,  1'b0, S_CFG,      32'hCAFEBABE,  3'd1); // dropped in HOLD
    add(1'b0, '0,     32'h0,         1'b1, S_CFG,      32'hCAFEBABE,  3'd1); // release, kept
    add(1'b0, '0,     32'h0,         1'b0, S_CFG,      32'hCAFEBABE,  3'd1); // idle bus
    add(1'b0, H_IO,   32'h12345678,  1'b0, S_IO,       32'h12345678,  3'd2); // IO
    add(1'b0, H_MEM4, 32'h0BADF00D,  1'b1, S_IO,       32'h12345678,  3'd2); // release edge ignores hdr
    add(1'b0, H_MEM4, 32'h0BADF00D,  1'b0, S_MEM4,     32'h0BADF00D,  3'd4); // mem 4DW
    add(1'b1, H_MEM3, 32'h55555555,  1'b1, '0,         32'h0,         3'd0); // reset in HOLD wins
    add(1'b0, H_MEM3, 32'h55555555,  1'b0, S_MEM3,     32'h55555555,  3'd3); // mem 3DW, DW3 ignored
    add(1'b0, '0,     32'h0,         1'b1, S_MEM3,     32'h55555555,  3'd3);
    add(1'b0, H_CPL,  32'h00000042,  1'b0, S_CPL,      32'h00000042,  3'd5); // default route
    add(1'b1, '0,     32'h0,         1'b0, '0,         32'h0,         3'd0);
    add(1'b0, H_LK4,  32'h77777777,  1'b0, S_LK4,      32'h77777777,  3'd4); // locked rd 4DW
    add(1'b0, '0,     32'h0,         1'b1, S_LK4,      32'h77777777,  3'd4);
    add(1'b0, H_CFG1, 32'h00000011,  1'b0, S_CFG1,     32'h00000011,  3'd1); // cfg1
    add(1'b0, '0,     32'h0,         1'b1, S_CFG1,     32'h00000011,  3'd1);
    add(1'b0, H_DW3,  32'h99999999,  1'b0, S_CFG1,     32'h00000011,  3'd1); // DW3 only: not a header
    add(1'b0, H_DW1,  32'h00000022,  1'b0, S_DW1,      32'h00000022,  3'd3); // DW0=0 still valid

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].hdr, vecs[i].pay, vecs[i].nr);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_sorted, vecs[i].e_pay, vecs[i].e_link);
    end

    // Long back-pressure: HOLD must survive many edges of competing headers.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i % 2 == 0) ? H_IO : H_CFG, 32'hFFFF0000 + 32'(i), 1'b0);
      check_outputs($sformatf("hold%0d", i), S_DW1, 32'h00000022, 3'd3);
    end

    // Release with header held high: captured exactly one edge after release.
    step(1'b0, H_CPL, 32'h0000ABCD, 1'b1);
    check_outputs("rel_same_edge", S_DW1, 32'h00000022, 3'd3);
    step(1'b0, H_CPL, 32'h0000ABCD, 1'b0);
    check_outputs("rel_next_edge", S_CPL, 32'h0000ABCD, 3'd5);

    // Reset then immediate capture on the first non-reset edge.
    step(1'b1, H_IO, 32'h1, 1'b0);
    check_outputs("rst_over_hdr", '0, 32'h0, 3'd0);
    step(1'b0, H_IO, 32'h2, 1'b0);
    check_outputs("post_rst_cap", S_IO, 32'h2, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
